pe_array_pipe: RTL and testbench
================================

Name: pe_array_pipe

Overview:
Parametrised, pipelined array of NUM_PE polar-decoder processing elements. Each lane computes the min-sum F and two G candidates, one per partial-sum hypothesis, from one LLR pair. The lane can also bypass its inputs unchanged. Results are registered behind a two-stage valid/ready pipeline with symmetric saturation and a saturation-event counter. The block sits between the LLR memory read port and the LLR write-back / decision logic of the SC/SCL decoder core.

Parameters:
INTER_LLR_WIDTH, 6, LLR width W in bits, two's complement
NUM_PE, 8, number of parallel lanes
SAT_CNT_WIDTH, 16, width of the saturation-event counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  pipeline can accept a beat this cycle
mode  input  2  00=F only, 01=G only, 10=F and G, 11=bypass
llr_in0  input  NUM_PE*W  lane i LLR a, at bits [i*W +: W]
llr_in1  input  NUM_PE*W  lane i LLR b
ps_g0  input  NUM_PE  partial-sum bit for G0, per lane
ps_g1  input  NUM_PE  partial-sum bit for G1, per lane
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
llr_out_f  output  NUM_PE*W  F result, or a in bypass
llr_out_g0  output  NUM_PE*W  G0 result, or b in bypass
llr_out_g1  output  NUM_PE*W  G1 result, zero in bypass
sat_cnt  output  SAT_CNT_WIDTH  count of accepted beats with at least one lane saturated; sticks at its maximum
sat_clr  input  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - All llr_out_* = 0, sat_cnt = 0.
  - in_ready = 1 once rst deasserts.
- Pipeline stages:
  - Stage 1 registers mode, llr_in0, llr_in1, ps_g0 and ps_g1.
  - Stage 2 registers the results.
  - Latency: 2 cycles from the accept edge to out_valid, with no stalls.
  - Throughput: 1 beat per cycle.
- Enables:
  - s2_en = ~s2_valid | out_ready
  - s1_en = ~s1_valid | s2_en
  - in_ready = s1_en; this path is combinational from out_ready, intentionally.
- Accept: a beat is accepted when in_valid & in_ready. Transfer out happens when out_valid & out_ready.
- Stall: outputs hold stable while out_valid=1 and out_ready=0. No beat is lost or duplicated.
- Bubbles: stage registers load only when their stage enable is high. Valid bits propagate independently, so bubbles collapse.
- F, per lane: sign = sign(a) XOR sign(b); magnitude = min(|a|,|b|).
  - |x| is computed at W+1 bits, then clipped to 2^(W-1)-1, so |-2^(W-1)| becomes 2^(W-1)-1.
- G, per lane: ps=0 gives b+a; ps=1 gives b-a.
  - Computed at W+1 bits.
  - Saturated symmetrically to [-(2^(W-1)-1), +(2^(W-1)-1)].
- Mode gating (inactive outputs are driven to 0):
  - F only: G outputs = 0.
  - G only: F output = 0.
  - F and G: all three outputs active.
  - Bypass: llr_out_f = a, llr_out_g0 = b, llr_out_g1 = 0; no saturation is applied.
- Saturation flag: a lane is flagged when an active F or G result was clipped. The flag for the beat is the OR over all lanes and is registered in stage 2.
- sat_cnt:
  - Increments by 1 when the flagged beat transfers out (out_valid & out_ready).
  - Holds at 2^SAT_CNT_WIDTH-1 once reached.
  - sat_clr wins over a simultaneous increment, so sat_cnt becomes 0.
- Reset mid-operation: in-flight beats are discarded and no partial output is presented. Behaviour after reset is identical to power-up.

Decomposition:
- Package pe_pkg holds:
  - mode constants MODE_F, MODE_G, MODE_FG, MODE_BYP
  - the symmetric-saturation limit function
  - the llr_t typedef, parametrised by W
- One natural sub-module: pe_lane. It is combinational and handles one lane: F, G0, G1, mode gating and the sat flag.
- The top level generates NUM_PE pe_lane instances and owns the pipeline registers, handshake and counter.

Test Plan:
- Basic F and G, W=6, mode=10, a=5, b=-3, ps_g0=0, ps_g1=1 -> after 2 cycles f=-3, g0=2, g1=-8; sat_cnt unchanged.
- Saturation, mode=01, a=20, b=20, ps_g0=0 and a=-32, b=-32, ps_g1=1 -> g0=31 with sat; then a=0, b=-32, ps_g0=0 -> g0=-31; sat_cnt counts 2 across the two beats.
- F edge case, a=-32, b=-32 -> f=+31 with sat; a=0, b=-7 -> f=0.
- Backpressure: 20 back-to-back beats with a random out_ready pattern -> outputs match the reference model in order, none lost or duplicated; held-stable check during stalls; in_ready=0 only while both stages are full and out_ready=0.
- Bypass and gating, mode=11, a=-9, b=14 -> f=-9, g0=14, g1=0, no sat; mode=00 -> g0=g1=0.
- Reset with 2 beats in flight -> out_valid=0 immediately and all outputs 0; sat_clr together with an increment -> sat_cnt=0; sat_cnt preloaded near maximum sticks at 65535.

Source files
------------

// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the polar-decoder PE array: lane mode encodings, the
// default LLR type and the symmetric saturation helper used by every lane.
// No ports (package).
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int LLR_W = 6;

  localparam logic [1:0] MODE_F   = 2'b00;
  localparam logic [1:0] MODE_G   = 2'b01;
  localparam logic [1:0] MODE_FG  = 2'b10;
  localparam logic [1:0] MODE_BYP = 2'b11;

  typedef logic signed [LLR_W-1:0] llr_t;

  // Saturation result: clipped value plus a flag telling whether clipping hit.
  typedef struct packed {
    logic signed [15:0] val;
    logic               sat;
  } sat_res_t;

  // Clip x to [-(2^(w-1)-1), +(2^(w-1)-1)]. Symmetric on purpose: the most
  // negative code is never produced, so negation of a result never overflows.
  function automatic sat_res_t sat_sym(input logic signed [15:0] x, input int unsigned w);
    sat_res_t          r;
    logic signed [15:0] lim;
    lim = 16'sd1;
    lim = (lim <<< (w - 1)) - 16'sd1;
    if (x > lim) begin
      r.val = lim;
      r.sat = 1'b1;
    end else if (x < -lim) begin
      r.val = -lim;
      r.sat = 1'b1;
    end else begin
      r.val = x;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_array_pipe_if.sv
// ----------------------------------------------------------------------------
// pe_array_pipe_if
// Input beat bus (valid/ready + LLR pairs, partial sums, mode) and output beat
// bus (valid/ready + F/G0/G1 results) of the PE array.
//   master : the side that produces input beats and consumes results
//   slave  : the PE array itself
// ----------------------------------------------------------------------------
interface pe_array_pipe_if #(
  parameter int W      = 6,
  parameter int NUM_PE = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [NUM_PE*W-1:0]   llr_in0;
  logic [NUM_PE*W-1:0]   llr_in1;
  logic [NUM_PE-1:0]     ps_g0;
  logic [NUM_PE-1:0]     ps_g1;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_PE*W-1:0]   llr_out_f;
  logic [NUM_PE*W-1:0]   llr_out_g0;
  logic [NUM_PE*W-1:0]   llr_out_g1;

  modport master (
    output in_valid, mode, llr_in0, llr_in1, ps_g0, ps_g1, out_ready,
    input  in_ready, out_valid, llr_out_f, llr_out_g0, llr_out_g1
  );

  modport slave (
    input  in_valid, mode, llr_in0, llr_in1, ps_g0, ps_g1, out_ready,
    output in_ready, out_valid, llr_out_f, llr_out_g0, llr_out_g1
  );
endinterface

// File: rtl/pe_lane.sv
// ----------------------------------------------------------------------------
// pe_lane
// Combinational single-lane polar PE: min-sum F, G0/G1 (one per partial-sum
// hypothesis), mode gating and saturation flag.
//   mode_i          lane operation (F / G / F+G / bypass)
//   a_i, b_i        LLR pair, two's complement
//   ps_g0_i/ps_g1_i partial-sum bit selecting b+a (0) or b-a (1)
//   f_o, g0_o, g1_o gated results
//   sat_o           an active F or G result was clipped
// ----------------------------------------------------------------------------
module pe_lane
  import pe_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [1:0]          mode_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic                ps_g0_i,
  input  logic                ps_g1_i,
  output logic signed [W-1:0] f_o,
  output logic signed [W-1:0] g0_o,
  output logic signed [W-1:0] g1_o,
  output logic                sat_o
);

  localparam logic [W:0] MAG_MAX = (W+1)'((1 << (W - 1)) - 1);

  logic signed [W:0]   a_ext_s, b_ext_s, f_val_s, g0_raw_s, g1_raw_s;
  logic [W:0]          abs_a_s, abs_b_s, mag_s;
  logic                f_clip_s;
  sat_res_t            g0_res_s, g1_res_s;
  logic signed [W-1:0] f_act_s, g0_act_s, g1_act_s;
  logic                unused_hi_bits_s;

  // Arithmetic at W+1 bits so |-2^(W-1)| and b+/-a never wrap before clipping.
  always_comb begin
    a_ext_s  = {a_i[W-1], a_i};
    b_ext_s  = {b_i[W-1], b_i};
    abs_a_s  = a_ext_s[W] ? unsigned'(-a_ext_s) : unsigned'(a_ext_s);
    abs_b_s  = b_ext_s[W] ? unsigned'(-b_ext_s) : unsigned'(b_ext_s);
    mag_s    = (abs_a_s < abs_b_s) ? abs_a_s : abs_b_s;
    f_clip_s = 1'b0;
    if (mag_s > MAG_MAX) begin
      mag_s    = MAG_MAX;
      f_clip_s = 1'b1;
    end else begin
      f_clip_s = 1'b0;
    end
    f_val_s  = (a_i[W-1] ^ b_i[W-1]) ? -$signed(mag_s) : $signed(mag_s);
    f_act_s  = f_val_s[W-1:0];
    g0_raw_s = ps_g0_i ? (b_ext_s - a_ext_s) : (b_ext_s + a_ext_s);
    g1_raw_s = ps_g1_i ? (b_ext_s - a_ext_s) : (b_ext_s + a_ext_s);
    g0_res_s = sat_sym(16'(g0_raw_s), W);
    g1_res_s = sat_sym(16'(g1_raw_s), W);
    g0_act_s = g0_res_s.val[W-1:0];
    g1_act_s = g1_res_s.val[W-1:0];
  end

  // Clipped values always fit in W bits; the upper bits are sign copies.
  assign unused_hi_bits_s = ^{g0_res_s.val[15:W], g1_res_s.val[15:W], f_val_s[W]};

  // Mode gating: inactive results are zero and cannot raise the sat flag.
  always_comb begin
    f_o   = '0;
    g0_o  = '0;
    g1_o  = '0;
    sat_o = 1'b0;
    case (mode_i)
      MODE_F: begin
        f_o   = f_act_s;
        sat_o = f_clip_s;
      end
      MODE_G: begin
        g0_o  = g0_act_s;
        g1_o  = g1_act_s;
        sat_o = g0_res_s.sat | g1_res_s.sat;
      end
      MODE_FG: begin
        f_o   = f_act_s;
        g0_o  = g0_act_s;
        g1_o  = g1_act_s;
        sat_o = f_clip_s | g0_res_s.sat | g1_res_s.sat;
      end
      MODE_BYP: begin
        f_o   = a_i;
        g0_o  = b_i;
      end
      default: begin
        f_o   = '0;
        g0_o  = '0;
        g1_o  = '0;
        sat_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pe_array_pipe.sv
// ----------------------------------------------------------------------------
// pe_array_pipe
// NUM_PE polar PE lanes behind a two-stage valid/ready pipeline, with a sticky
// count of output beats in which any lane saturated.
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   bus       slave side of pe_array_pipe_if (input beats in, results out)
//   sat_clr   synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt   saturated-beat counter, holds at all-ones
// ----------------------------------------------------------------------------
module pe_array_pipe
  import pe_pkg::*;
#(
  parameter int INTER_LLR_WIDTH = 6,
  parameter int NUM_PE          = 8,
  parameter int SAT_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_array_pipe_if.slave           bus,
  input  logic                     sat_clr,
  output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);

  localparam int W  = INTER_LLR_WIDTH;
  localparam int VW = NUM_PE * W;

  logic                     s1_valid_q, s2_valid_q, s2_sat_q;
  logic [1:0]               s1_mode_q;
  logic [VW-1:0]            s1_a_q, s1_b_q;
  logic [NUM_PE-1:0]        s1_ps0_q, s1_ps1_q;
  logic [VW-1:0]            s2_f_q, s2_g0_q, s2_g1_q;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

  logic [VW-1:0]            lane_f_s, lane_g0_s, lane_g1_s;
  logic [NUM_PE-1:0]        lane_sat_s;
  logic                     s1_en_s, s2_en_s, sat_inc_s;

  // in_ready follows out_ready combinationally so a full pipe still moves at
  // one beat per cycle when the consumer is ready.
  assign s2_en_s      = ~s2_valid_q | bus.out_ready;
  assign s1_en_s      = ~s1_valid_q | s2_en_s;
  assign bus.in_ready = s1_en_s;
  assign sat_inc_s    = s2_valid_q & bus.out_ready & s2_sat_q;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    pe_lane #(.W(W)) u_lane (
      .mode_i  (s1_mode_q),
      .a_i     (s1_a_q[i*W +: W]),
      .b_i     (s1_b_q[i*W +: W]),
      .ps_g0_i (s1_ps0_q[i]),
      .ps_g1_i (s1_ps1_q[i]),
      .f_o     (lane_f_s[i*W +: W]),
      .g0_o    (lane_g0_s[i*W +: W]),
      .g1_o    (lane_g1_s[i*W +: W]),
      .sat_o   (lane_sat_s[i])
    );
  end

  // Stage 1: capture the input beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 2'b00;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ps0_q   <= '0;
      s1_ps1_q   <= '0;
    end else if (s1_en_s) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_q <= bus.mode;
        s1_a_q    <= bus.llr_in0;
        s1_b_q    <= bus.llr_in1;
        s1_ps0_q  <= bus.ps_g0;
        s1_ps1_q  <= bus.ps_g1;
      end
    end
  end

  // Stage 2: capture lane results and the beat-level saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
      s2_g0_q    <= '0;
      s2_g1_q    <= '0;
      s2_sat_q   <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_f_q   <= lane_f_s;
        s2_g0_q  <= lane_g0_s;
        s2_g1_q  <= lane_g1_s;
        s2_sat_q <= |lane_sat_s;
      end
    end
  end

  // Saturated-beat counter: counts on transfer out, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (sat_clr) begin
      sat_cnt_q <= '0;
    end else if (sat_inc_s && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + SAT_CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.llr_out_f  = s2_f_q;
  assign bus.llr_out_g0 = s2_g0_q;
  assign bus.llr_out_g1 = s2_g1_q;
  assign sat_cnt        = sat_cnt_q;

endmodule

// File: tb/tb_pe_array_pipe.sv
// ----------------------------------------------------------------------------
// tb_pe_array_pipe
// Directed scenarios for pe_array_pipe with hand-computed expected values and
// a small integer reference model for the randomised backpressure run.
// ----------------------------------------------------------------------------
module tb_pe_array_pipe;
  import pe_pkg::*;

  localparam int W  = 6;
  localparam int N  = 8;
  localparam int VW = N * W;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clr;
  logic [15:0] sat_cnt;
  int          errors = 0;
  int          checks = 0;

  pe_array_pipe_if #(.W(W), .NUM_PE(N)) bus ();

  pe_array_pipe #(.INTER_LLR_WIDTH(W), .NUM_PE(N), .SAT_CNT_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0;
    bus.mode     = MODE_FG;
    bus.llr_in0  = '0;
    bus.llr_in1  = '0;
    bus.ps_g0    = '0;
    bus.ps_g1    = '0;
  endtask

  task automatic set_lane(input int i, input int a, input int b, input logic p0, input logic p1);
    logic [W-1:0] av, bv;
    av = a[W-1:0];
    bv = b[W-1:0];
    bus.llr_in0[i*W +: W] = av;
    bus.llr_in1[i*W +: W] = bv;
    bus.ps_g0[i] = p0;
    bus.ps_g1[i] = p1;
  endtask

  task automatic send_beat();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  function automatic int lane_val(input logic [VW-1:0] v, input int i);
    logic signed [W-1:0] t;
    t = v[i*W +: W];
    return int'(t);
  endfunction

  function automatic int clip31(input int x);
    if (x > 31) return 31;
    if (x < -31) return -31;
    return x;
  endfunction

  // Integer reference for one beat; returns {f, g0, g1}.
  function automatic logic [3*VW-1:0] ref_beat(input logic [1:0] m, input logic [VW-1:0] x0,
                                               input logic [VW-1:0] x1, input logic [N-1:0] p0,
                                               input logic [N-1:0] p1);
    logic [VW-1:0] f, g0, g1;
    int a, b, ma, mb, mag, fv, s0, s1, rf, r0, r1;
    for (int i = 0; i < N; i++) begin
      a   = lane_val(x0, i);
      b   = lane_val(x1, i);
      ma  = (a < 0) ? -a : a;
      mb  = (b < 0) ? -b : b;
      mag = (ma < mb) ? ma : mb;
      if (mag > 31) mag = 31;
      fv  = ((a < 0) != (b < 0)) ? -mag : mag;
      s0  = clip31(p0[i] ? b - a : b + a);
      s1  = clip31(p1[i] ? b - a : b + a);
      case (m)
        2'd0:    begin rf = fv; r0 = 0;  r1 = 0;  end
        2'd1:    begin rf = 0;  r0 = s0; r1 = s1; end
        2'd2:    begin rf = fv; r0 = s0; r1 = s1; end
        default: begin rf = a;  r0 = b;  r1 = 0;  end
      endcase
      f[i*W +: W]  = rf[W-1:0];
      g0[i*W +: W] = r0[W-1:0];
      g1[i*W +: W] = r1[W-1:0];
    end
    return {f, g0, g1};
  endfunction

  task automatic test_reset();
    rst = 1'b1; sat_clr = 1'b0; bus.out_ready = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if ({bus.llr_out_f, bus.llr_out_g0, bus.llr_out_g1} !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {bus.llr_out_f, bus.llr_out_g0, bus.llr_out_g1}); end
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
  endtask

  task automatic test_basic_fg();
    clear_inputs();
    bus.mode = MODE_FG;
    set_lane(0, 5, -3, 1'b0, 1'b1);
    set_lane(7, 7, 9, 1'b1, 1'b1);
    send_beat();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1: out_valid got %0b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2: out_valid got %0b want 1", bus.out_valid); end
    checks++; if (lane_val(bus.llr_out_f, 0) != -3) begin errors++; $display("FAIL basic_f0: got %0d want -3", lane_val(bus.llr_out_f, 0)); end
    checks++; if (lane_val(bus.llr_out_g0, 0) != 2) begin errors++; $display("FAIL basic_g0_0: got %0d want 2", lane_val(bus.llr_out_g0, 0)); end
    checks++; if (lane_val(bus.llr_out_g1, 0) != -8) begin errors++; $display("FAIL basic_g1_0: got %0d want -8", lane_val(bus.llr_out_g1, 0)); end
    checks++; if (lane_val(bus.llr_out_f, 7) != 7) begin errors++; $display("FAIL basic_f7: got %0d want 7", lane_val(bus.llr_out_f, 7)); end
    checks++; if (lane_val(bus.llr_out_g0, 7) != 2) begin errors++; $display("FAIL basic_g0_7: got %0d want 2", lane_val(bus.llr_out_g0, 7)); end
    checks++; if (lane_val(bus.llr_out_g1, 3) != 0) begin errors++; $display("FAIL basic_g1_3: got %0d want 0", lane_val(bus.llr_out_g1, 3)); end
    tick();
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL basic_sat_cnt: got %0d want 0", sat_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: out_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    bus.mode = MODE_G;
    set_lane(0, 20, 20, 1'b0, 1'b0);
    set_lane(1, -32, -32, 1'b0, 1'b1);
    send_beat();
    tick();
    checks++; if (lane_val(bus.llr_out_g0, 0) != 31) begin errors++; $display("FAIL sat_g0_pos: got %0d want 31", lane_val(bus.llr_out_g0, 0)); end
    checks++; if (lane_val(bus.llr_out_g0, 1) != -31) begin errors++; $display("FAIL sat_g0_neg: got %0d want -31", lane_val(bus.llr_out_g0, 1)); end
    checks++; if (lane_val(bus.llr_out_g1, 1) != 0) begin errors++; $display("FAIL sat_g1_diff: got %0d want 0", lane_val(bus.llr_out_g1, 1)); end
    checks++; if (bus.llr_out_f !== '0) begin errors++; $display("FAIL sat_f_gated: got %h want 0", bus.llr_out_f); end
    set_lane(0, 0, -32, 1'b0, 1'b0);
    set_lane(1, 0, 0, 1'b0, 1'b0);
    send_beat();
    checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt_1: got %0d want 1", sat_cnt); end
    tick();
    checks++; if (lane_val(bus.llr_out_g0, 0) != -31) begin errors++; $display("FAIL sat_g0_min: got %0d want -31", lane_val(bus.llr_out_g0, 0)); end
    tick();
    checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt_2: got %0d want 2", sat_cnt); end
  endtask

  task automatic test_f_edge();
    clear_inputs();
    bus.mode = MODE_F;
    set_lane(0, -32, -32, 1'b0, 1'b0);
    set_lane(1, 0, -7, 1'b0, 1'b0);
    send_beat();
    tick();
    checks++; if (lane_val(bus.llr_out_f, 0) != 31) begin errors++; $display("FAIL fedge_f0: got %0d want 31", lane_val(bus.llr_out_f, 0)); end
    checks++; if (lane_val(bus.llr_out_f, 1) != 0) begin errors++; $display("FAIL fedge_f1: got %0d want 0", lane_val(bus.llr_out_f, 1)); end
    checks++; if ({bus.llr_out_g0, bus.llr_out_g1} !== '0) begin errors++; $display("FAIL fedge_g_gated: got %h want 0", {bus.llr_out_g0, bus.llr_out_g1}); end
    tick();
    checks++; if (sat_cnt !== 16'd3) begin errors++; $display("FAIL fedge_sat_cnt: got %0d want 3", sat_cnt); end
  endtask

  task automatic test_bypass_gating();
    clear_inputs();
    bus.mode = MODE_BYP;
    set_lane(0, -9, 14, 1'b1, 1'b1);
    set_lane(1, -32, -32, 1'b0, 1'b0);
    send_beat();
    tick();
    checks++; if (lane_val(bus.llr_out_f, 0) != -9) begin errors++; $display("FAIL byp_f: got %0d want -9", lane_val(bus.llr_out_f, 0)); end
    checks++; if (lane_val(bus.llr_out_g0, 0) != 14) begin errors++; $display("FAIL byp_g0: got %0d want 14", lane_val(bus.llr_out_g0, 0)); end
    checks++; if (lane_val(bus.llr_out_f, 1) != -32) begin errors++; $display("FAIL byp_f_raw: got %0d want -32", lane_val(bus.llr_out_f, 1)); end
    checks++; if (bus.llr_out_g1 !== '0) begin errors++; $display("FAIL byp_g1: got %h want 0", bus.llr_out_g1); end
    tick();
    checks++; if (sat_cnt !== 16'd3) begin errors++; $display("FAIL byp_no_sat: got %0d want 3", sat_cnt); end
    clear_inputs();
    bus.mode = MODE_F;
    set_lane(0, 5, -3, 1'b0, 1'b1);
    send_beat();
    tick();
    checks++; if (lane_val(bus.llr_out_f, 0) != -3) begin errors++; $display("FAIL fonly_f: got %0d want -3", lane_val(bus.llr_out_f, 0)); end
    checks++; if ({bus.llr_out_g0, bus.llr_out_g1} !== '0) begin errors++; $display("FAIL fonly_g_gated: got %h want 0", {bus.llr_out_g0, bus.llr_out_g1}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3*VW-1:0] expq[$];
    logic [3*VW-1:0] held, exp_v, got_v;
    logic [63:0]     r0, r1;
    logic            stalled, acc, xfer, exp_ready;
    int              sent, got, inflight;
    sent = 0; got = 0; inflight = 0; stalled = 1'b0; held = '0;
    clear_inputs();
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      if (!bus.in_valid && sent < 20) begin
        r0 = {$urandom(), $urandom()};
        r1 = {$urandom(), $urandom()};
        bus.llr_in0  = r0[VW-1:0];
        bus.llr_in1  = r1[VW-1:0];
        bus.ps_g0    = 8'($urandom_range(0, 255));
        bus.ps_g1    = 8'($urandom_range(0, 255));
        bus.mode     = 2'($urandom_range(0, 3));
        bus.in_valid = 1'b1;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      got_v     = {bus.llr_out_f, bus.llr_out_g0, bus.llr_out_g1};
      exp_ready = !(inflight == 2 && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %0b want %0b", cyc, bus.in_ready, exp_ready); end
      if (stalled) begin
        checks++; if (bus.out_valid !== 1'b1 || got_v !== held) begin errors++; $display("FAIL bp_hold: cycle %0d got %h want %h", cyc, got_v, held); end
      end
      acc  = bus.in_valid & bus.in_ready;
      xfer = bus.out_valid & bus.out_ready;
      if (xfer) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat: cycle %0d got %h want none", cyc, got_v);
        end else begin
          exp_v = expq.pop_front();
          if (got_v !== exp_v) begin errors++; $display("FAIL bp_data: beat %0d got %h want %h", got, got_v, exp_v); end
        end
        got++;
      end
      stalled = bus.out_valid & ~bus.out_ready;
      held    = got_v;
      if (acc) expq.push_back(ref_beat(bus.mode, bus.llr_in0, bus.llr_in1, bus.ps_g0, bus.ps_g1));
      tick();
      if (acc) begin sent++; inflight++; bus.in_valid = 1'b0; end
      if (xfer) inflight--;
    end
    checks++; if (got != 20 || expq.size() != 0) begin errors++; $display("FAIL bp_count: got %0d beats want 20 (pending %0d)", got, expq.size()); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    bus.out_ready = 1'b1;
    bus.mode = MODE_FG;
    set_lane(0, 5, -3, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: out_valid got %0b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
    checks++; if ({bus.llr_out_f, bus.llr_out_g0, bus.llr_out_g1} !== '0) begin errors++; $display("FAIL mid_rst_outputs: got %h want 0", {bus.llr_out_f, bus.llr_out_g0, bus.llr_out_g1}); end
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_sat_cnt: got %0d want 0", sat_cnt); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: out_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_sat_clr();
    clear_inputs();
    bus.out_ready = 1'b1;
    bus.mode = MODE_F;
    set_lane(0, -32, -32, 1'b0, 1'b0);
    send_beat();
    tick();
    tick();
    checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre: got %0d want 1", sat_cnt); end
    send_beat();
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_beat_ready: out_valid got %0b want 1", bus.out_valid); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", sat_cnt); end
  endtask

  task automatic test_sat_sticky();
    clear_inputs();
    bus.out_ready = 1'b1;
    bus.mode = MODE_F;
    set_lane(0, -32, -32, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (sat_cnt !== 16'hFFFF) begin errors++; $display("FAIL sticky_max: got %0d want 65535", sat_cnt); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL sticky_clear: got %0d want 0", sat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_fg();
    test_saturation();
    test_f_edge();
    test_bypass_gating();
    test_back_to_back();
    test_reset_midflight();
    test_sat_clr();
    test_sat_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
